// File: rtl/mlp_pkg.sv
// Shared types and constants for the sequential MLP layer controller.
package mlp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_RELU,
      S_DONE
   } state_e;

   // out_valid rises N_INPUTS + OUT_LAT_OFFSET cycles after the accept cycle
   localparam int unsigned OUT_LAT_OFFSET = 4;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mlp_layer_seq.sv
// Sequencer that streams one input vector through an MLP layer's MAC array.
// Optional inference counter is built when MLP_SEQ_PERF_CNT_EN is defined.
module mlp_layer_seq
   import mlp_pkg::*;
#(
   parameter int unsigned N_INPUTS   = 2,
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned PERF_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [N_INPUTS*IN_WIDTH-1:0]     in_data_flat,
   output logic                             out_valid,
   input  logic                             out_ready,
   input  logic                             cfg_wr_en,
   output logic                             cfg_wr_ready,
   output logic                             layer_wr_en,
   output logic                             layer_start,
   output logic [idx_width(N_INPUTS)-1:0]   layer_index,
   output logic [IN_WIDTH-1:0]              layer_value,
   output logic                             layer_valid,
   output logic                             layer_relu_en
`ifdef MLP_SEQ_PERF_CNT_EN
   ,output logic [PERF_WIDTH-1:0]           perf_count
`endif
);

   localparam int unsigned IDX_W = idx_width(N_INPUTS);

   if (N_INPUTS < 1 || PERF_WIDTH < 1) begin : g_param_chk
      $error("mlp_layer_seq: N_INPUTS and PERF_WIDTH must be at least 1");
   end

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [IN_WIDTH-1:0] vec_q [N_INPUTS];
   logic [IN_WIDTH-1:0] vec_d [N_INPUTS];
   logic                lvalid_q, lvalid_d;
   logic [IN_WIDTH-1:0] lvalue_q, lvalue_d;
   logic                accept;

   // A weight write in IDLE wins over a vector offered in the same cycle
   assign in_ready      = !rst && (state_q == S_IDLE) && !cfg_wr_en;
   assign cfg_wr_ready  = !rst && (state_q == S_IDLE);
   assign layer_wr_en   = cfg_wr_en && cfg_wr_ready;
   assign accept        = in_valid && in_ready;
   assign layer_start   = (state_q == S_CLEAR);
   assign layer_relu_en = (state_q == S_RELU);
   assign out_valid     = (state_q == S_DONE);
   assign layer_index   = cnt_q;
   assign layer_valid   = lvalid_q;
   assign layer_value   = lvalue_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vec_d    = vec_q;
      lvalid_d = 1'b0;
      lvalue_d = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               for (int unsigned k = 0; k < N_INPUTS; k++) begin
                  vec_d[k] = in_data_flat[k*IN_WIDTH +: IN_WIDTH];
               end
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            // Element lands one cycle after its index to line up with the weight read
            lvalid_d = 1'b1;
            lvalue_d = vec_q[cnt_q];
            if (cnt_q == IDX_W'(N_INPUTS - 1)) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         S_DRAIN: state_d = S_RELU;
         S_RELU:  state_d = S_DONE;
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         lvalid_q <= 1'b0;
         lvalue_q <= '0;
         for (int unsigned k = 0; k < N_INPUTS; k++) begin
            vec_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lvalid_q <= lvalid_d;
         lvalue_q <= lvalue_d;
         vec_q    <= vec_d;
      end
   end

`ifdef MLP_SEQ_PERF_CNT_EN
   logic [PERF_WIDTH-1:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == S_DONE && out_ready) begin
         perf_d = perf_q + PERF_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Directed bench for mlp_layer_seq: a 2-element instance and a 1-element instance.
module tb_mlp_layer_seq;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready, cfg_wr_en;
   logic        cfg_wr_ready, layer_wr_en, layer_start, layer_valid, layer_relu_en;
   logic [31:0] in_data;
   logic [0:0]  layer_index;
   logic [15:0] layer_value;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, cfg_wr_en1;
   logic        cfg_wr_ready1, layer_wr_en1, layer_start1, layer_valid1, layer_relu_en1;
   logic [15:0] in_data1;
   logic [0:0]  layer_index1;
   logic [15:0] layer_value1;

`ifdef MLP_SEQ_PERF_CNT_EN
   logic [31:0] perf_count, perf_count1;
`endif

   int checks = 0;
   int errors = 0;
   int exp_perf = 0;

   always #5 clk = ~clk;

   mlp_layer_seq #(.N_INPUTS(2), .IN_WIDTH(16), .PERF_WIDTH(32)) u0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data_flat(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_ready(cfg_wr_ready), .layer_wr_en(layer_wr_en),
      .layer_start(layer_start), .layer_index(layer_index), .layer_value(layer_value),
      .layer_valid(layer_valid), .layer_relu_en(layer_relu_en)
`ifdef MLP_SEQ_PERF_CNT_EN
      , .perf_count(perf_count)
`endif
   );

   mlp_layer_seq #(.N_INPUTS(1), .IN_WIDTH(16), .PERF_WIDTH(32)) u1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data_flat(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .cfg_wr_en(cfg_wr_en1), .cfg_wr_ready(cfg_wr_ready1), .layer_wr_en(layer_wr_en1),
      .layer_start(layer_start1), .layer_index(layer_index1), .layer_value(layer_value1),
      .layer_valid(layer_valid1), .layer_relu_en(layer_relu_en1)
`ifdef MLP_SEQ_PERF_CNT_EN
      , .perf_count(perf_count1)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          dly;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full inference on u0; cycle 0 is the accept cycle
   task automatic run_vec(input vec_t v);
      in_data   = {v.b, v.a};
      in_valid  = 1'b1;
      out_ready = (v.dly == 0);
      #1;
      chk("accept_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      chk("c1_start", layer_start, 1);
      chk("c1_in_ready", in_ready, 0);
      tick();
      chk("c2_start", layer_start, 0);
      chk("c2_index", layer_index, 0);
      chk("c2_valid", layer_valid, 0);
      tick();
      chk("c3_index", layer_index, 1);
      chk("c3_valid", layer_valid, 1);
      chk("c3_value", layer_value, v.a);
      tick();
      chk("c4_valid", layer_valid, 1);
      chk("c4_value", layer_value, v.b);
      chk("c4_relu", layer_relu_en, 0);
      tick();
      chk("c5_relu", layer_relu_en, 1);
      chk("c5_valid", layer_valid, 0);
      chk("c5_value", layer_value, 0);
      chk("c5_out_valid", out_valid, 0);
      tick();
      chk("c6_out_valid", out_valid, 1);
      chk("c6_relu", layer_relu_en, 0);
      for (int i = 0; i < v.dly; i++) begin
         in_valid = 1'b1;
         tick();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_no_start", layer_start, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      exp_perf++;
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
`ifdef MLP_SEQ_PERF_CNT_EN
      chk("perf_count", perf_count, 32'(exp_perf));
`endif
   endtask

   initial begin
      tbl[0] = '{16'd3,     16'hFFFE, 0};
      tbl[1] = '{16'h7FFF,  16'h8000, 0};
      tbl[2] = '{16'd0,     16'd1,    0};
      tbl[3] = '{16'hFFFF,  16'd100,  5};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; cfg_wr_en = 1'b0; in_data = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; cfg_wr_en1 = 1'b0; in_data1 = '0;
      tick();
      chk("rst_start", layer_start, 0);
      chk("rst_valid", layer_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_cfg_ready", cfg_wr_ready, 1);
`ifdef MLP_SEQ_PERF_CNT_EN
      chk("rst_perf", perf_count, 0);
`endif

      for (int t = 0; t < 4; t++) begin
         run_vec(tbl[t]);
      end

      // Weight write blocked mid-stream, prioritised in IDLE
      in_data = {16'd6, 16'd5};
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      cfg_wr_en = 1'b1;
      #1;
      chk("stream_cfg_ready", cfg_wr_ready, 0);
      chk("stream_wr_en", layer_wr_en, 0);
      cfg_wr_en = 1'b0;
      repeat (5) tick();
      exp_perf++;
      chk("cfg_seq_idle", in_ready, 1);
      cfg_wr_en = 1'b1; in_valid = 1'b1;
      #1;
      chk("idle_wr_en", layer_wr_en, 1);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_cfg_ready", cfg_wr_ready, 1);
      tick();
      chk("idle_no_accept", layer_start, 0);
      cfg_wr_en = 1'b0; in_valid = 1'b0;
      #1;
      chk("idle_in_ready_after", in_ready, 1);
`ifdef MLP_SEQ_PERF_CNT_EN
      chk("perf_after_cfg", perf_count, 32'(exp_perf));
`endif

      // Single-element instance
      in_data1 = 16'd7; in_valid1 = 1'b1;
      #1;
      chk("n1_in_ready", in_ready1, 1);
      tick();
      in_valid1 = 1'b0;
      chk("n1_start", layer_start1, 1);
      tick();
      chk("n1_index", layer_index1, 0);
      chk("n1_valid_c2", layer_valid1, 0);
      tick();
      chk("n1_valid_c3", layer_valid1, 1);
      chk("n1_value_c3", layer_value1, 16'd7);
      tick();
      chk("n1_valid_c4", layer_valid1, 0);
      chk("n1_relu_c4", layer_relu_en1, 1);
      chk("n1_out_valid_c4", out_valid1, 0);
      tick();
      chk("n1_out_valid_c5", out_valid1, 1);
      tick();
      chk("n1_out_valid_c6", out_valid1, 0);
`ifdef MLP_SEQ_PERF_CNT_EN
      chk("n1_perf", perf_count1, 1);
`endif

      // Asynchronous reset in the middle of STREAM
      in_data = {16'd9, 16'd8}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_valid_pre", layer_valid, 1);
      rst = 1'b1;
      #1;
      exp_perf = 0;
      chk("mid_rst_valid", layer_valid, 0);
      chk("mid_rst_value", layer_value, 0);
      chk("mid_rst_index", layer_index, 0);
      chk("mid_rst_start", layer_start, 0);
      chk("mid_rst_relu", layer_relu_en, 0);
      chk("mid_rst_out_valid", out_valid, 0);
`ifdef MLP_SEQ_PERF_CNT_EN
      chk("mid_rst_perf", perf_count, 0);
`endif
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rel_in_ready", in_ready, 1);
      chk("mid_rel_cfg_ready", cfg_wr_ready, 1);
      tick();
      chk("mid_rel_idle", layer_start, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
